// File: rtl/multdiv_sequencer.sv
// Launches the multi-cycle mul/div unit from DX, stalls PC/FD/DX and bubbles XM until the unit answers,
// then presents a one-cycle registered result (or error code to r30) for the XM input mux.
module multdiv_sequencer #(
    parameter int TIMEOUT      = 64,
    parameter int MUL_ERR_CODE = 4,
    parameter int DIV_ERR_CODE = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DX_Latch_Instr,
    input  logic [31:0] DX_A_operand,
    input  logic [31:0] DX_B_operand,
    input  logic        flush,
    input  logic        multdiv_resultRDY,
    input  logic        multdiv_exception,
    input  logic [31:0] multdiv_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_stall,
    output logic        md_XM_bubble,
    output logic        md_done,
    output logic [31:0] md_result,
    output logic [4:0]  md_rd,
    output logic        md_error,
    output logic        md_busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [31:0]      MUL_ERR  = 32'(MUL_ERR_CODE);
    localparam logic [31:0]      DIV_ERR  = 32'(DIV_ERR_CODE);
    localparam logic [4:0]       ERR_RD   = 5'd30;
    localparam logic [4:0]       ALU_MUL  = 5'd6;
    localparam logic [4:0]       ALU_DIV  = 5'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      opa_q;
    logic [31:0]      opb_q;
    logic [4:0]       rd_q;
    logic             op_div_q;
    logic             mult_q;
    logic             div_q;
    logic             done_q;
    logic [31:0]      res_q;
    logic [4:0]       rd_out_q;
    logic             err_q;

    logic [4:0] dx_opcode;
    logic [4:0] dx_alu_op;
    logic [4:0] dx_rd;
    logic       dx_is_mul;
    logic       dx_is_div;
    logic       dx_is_md;
    logic       launch;
    logic       timeout_hit;
    logic       unused_instr_bits;

    assign dx_opcode = DX_Latch_Instr[31:27];
    assign dx_rd     = DX_Latch_Instr[26:22];
    assign dx_alu_op = DX_Latch_Instr[6:2];
    assign dx_is_mul = (dx_opcode == 5'd0) && (dx_alu_op == ALU_MUL);
    assign dx_is_div = (dx_opcode == 5'd0) && (dx_alu_op == ALU_DIV);
    assign dx_is_md  = dx_is_mul || dx_is_div;
    assign launch    = dx_is_md && !flush;

    assign unused_instr_bits = ^{DX_Latch_Instr[21:7], DX_Latch_Instr[1:0]};

    // Saturating so a mis-sized TIMEOUT can never wrap back into a live count.
    assign cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            rd_q     <= '0;
            op_div_q <= 1'b0;
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            rd_out_q <= '0;
            err_q    <= 1'b0;
        end else begin
            mult_q   <= 1'b0;
            div_q    <= 1'b0;
            done_q   <= 1'b0;
            res_q    <= '0;
            rd_out_q <= '0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (launch) begin
                        opa_q    <= DX_A_operand;
                        opb_q    <= DX_B_operand;
                        rd_q     <= dx_rd;
                        op_div_q <= dx_is_div;
                        mult_q   <= dx_is_mul;
                        div_q    <= dx_is_div;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    // A resultRDY here belongs to an older launch and is dropped.
                    cnt_q   <= '0;
                    state_q <= flush ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else if (multdiv_resultRDY) begin
                        done_q   <= 1'b1;
                        err_q    <= multdiv_exception;
                        rd_out_q <= multdiv_exception ? ERR_RD : rd_q;
                        res_q    <= !multdiv_exception ? multdiv_result :
                                    (op_div_q ? DIV_ERR : MUL_ERR);
                        state_q  <= S_DONE;
                    end else if (timeout_hit) begin
                        done_q   <= 1'b1;
                        err_q    <= 1'b1;
                        rd_out_q <= ERR_RD;
                        res_q    <= DIV_ERR;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        md_stall = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IDLE:  md_stall = launch;
                S_START: md_stall = 1'b1;
                S_WAIT:  md_stall = 1'b1;
                default: md_stall = 1'b0;
            endcase
        end
    end

    assign md_XM_bubble = md_stall;
    assign md_busy      = (state_q != S_IDLE);
    assign ctrl_MULT    = mult_q;
    assign ctrl_DIV     = div_q;
    assign md_operandA  = opa_q;
    assign md_operandB  = opb_q;
    assign md_done      = done_q;
    assign md_result    = res_q;
    assign md_rd        = rd_out_q;
    assign md_error     = err_q;

    a_one_start: assert property (@(posedge clock) disable iff (reset) !(ctrl_MULT && ctrl_DIV));
    a_pulse:     assert property (@(posedge clock) disable iff (reset) (ctrl_MULT || ctrl_DIV) |=> !(ctrl_MULT || ctrl_DIV));
    a_done_free: assert property (@(posedge clock) disable iff (reset) md_done |-> !md_stall);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomized and directed bench for multdiv_sequencer against a cycle-timeline model of the mul/div handshake.
module tb_multdiv_sequencer;

    localparam int          TO  = 64;
    localparam logic [31:0] NOP = 32'h0;

    logic        clock;
    logic        reset;
    logic [31:0] DX_Latch_Instr;
    logic [31:0] DX_A_operand;
    logic [31:0] DX_B_operand;
    logic        flush;
    logic        multdiv_resultRDY;
    logic        multdiv_exception;
    logic [31:0] multdiv_result;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_stall;
    logic        md_XM_bubble;
    logic        md_done;
    logic [31:0] md_result;
    logic [4:0]  md_rd;
    logic        md_error;
    logic        md_busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit spur    = 1'b0;

    multdiv_sequencer #(.TIMEOUT(TO), .MUL_ERR_CODE(4), .DIV_ERR_CODE(5)) dut (
        .clock            (clock),
        .reset            (reset),
        .DX_Latch_Instr   (DX_Latch_Instr),
        .DX_A_operand     (DX_A_operand),
        .DX_B_operand     (DX_B_operand),
        .flush            (flush),
        .multdiv_resultRDY(multdiv_resultRDY),
        .multdiv_exception(multdiv_exception),
        .multdiv_result   (multdiv_result),
        .ctrl_MULT        (ctrl_MULT),
        .ctrl_DIV         (ctrl_DIV),
        .md_operandA      (md_operandA),
        .md_operandB      (md_operandB),
        .md_stall         (md_stall),
        .md_XM_bubble     (md_XM_bubble),
        .md_done          (md_done),
        .md_result        (md_result),
        .md_rd            (md_rd),
        .md_error         (md_error),
        .md_busy          (md_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_md(input bit is_div, input logic [4:0] rd);
        logic [4:0] alu;
        alu = is_div ? 5'd7 : 5'd6;
        return {5'd0, rd, 5'($urandom), 5'($urandom), 5'($urandom), alu, 2'($urandom)};
    endfunction

    // One mul/div as seen from DX: RDY in cycle k (k>=2), optional flush in cycle f (f>=1, 0 = none).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input bit exc, input int f, input bit tail);
        logic [31:0] instr, unit_res, exp_res;
        logic [4:0]  exp_rd;
        logic        exp_err;
        int          done_c, end_c, last;
        bit          aborted, in_dx;
        instr    = enc_md(is_div, rd);
        unit_res = is_div ? a / b : a * b;
        aborted  = (f > 0);
        if (k <= TO + 1) begin
            done_c  = k + 1;
            exp_err = exc;
            exp_rd  = exc ? 5'd30 : rd;
            exp_res = !exc ? unit_res : (is_div ? 32'd5 : 32'd4);
        end else begin
            done_c  = TO + 2;
            exp_err = 1'b1;
            exp_rd  = 5'd30;
            exp_res = 32'd5;
        end
        end_c = aborted ? f : done_c;
        last  = aborted ? ((k > f) ? k : f) + 1 : (tail ? done_c + 1 : done_c);
        for (int c = 0; c <= last; c++) begin
            @(negedge clock);
            in_dx             = (c <= end_c);
            DX_Latch_Instr    = in_dx ? instr : NOP;
            DX_A_operand      = in_dx ? a : $urandom;
            DX_B_operand      = in_dx ? b : $urandom;
            flush             = aborted && (c == f);
            multdiv_resultRDY = (c == k) || (spur && c == 1);
            multdiv_exception = ((c == k) && exc) || (spur && c == 1);
            multdiv_result    = (c == k) ? unit_res : $urandom;
            #1;
            check_eq($sformatf("stall c%0d", c), md_stall, (c <= (aborted ? f : done_c - 1)));
            check_eq($sformatf("bubble c%0d", c), md_XM_bubble, (c <= (aborted ? f : done_c - 1)));
            check_eq($sformatf("mult c%0d", c), ctrl_MULT, (c == 1 && !is_div));
            check_eq($sformatf("div c%0d", c), ctrl_DIV, (c == 1 && is_div));
            check_eq($sformatf("busy c%0d", c), md_busy, (c >= 1 && c <= end_c));
            check_eq($sformatf("done c%0d", c), md_done, (!aborted && c == done_c));
            if (!aborted && c == done_c) begin
                check_eq($sformatf("result c%0d", c), md_result, exp_res);
                check_eq($sformatf("rd c%0d", c), md_rd, exp_rd);
                check_eq($sformatf("error c%0d", c), md_error, exp_err);
            end else begin
                check_eq($sformatf("result0 c%0d", c), md_result, 32'd0);
                check_eq($sformatf("rd0 c%0d", c), md_rd, 32'd0);
                check_eq($sformatf("error0 c%0d", c), md_error, 32'd0);
            end
            if (c >= 1) begin
                check_eq($sformatf("opA c%0d", c), md_operandA, a);
                check_eq($sformatf("opB c%0d", c), md_operandB, b);
            end
        end
    endtask

    // Non-md traffic and flushed md instructions must never stall or launch.
    task automatic idle_cycles(input int n);
        int          kind;
        logic [4:0]  alu;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            kind  = $urandom_range(0, 2);
            flush = 1'b0;
            if (kind == 0) begin
                DX_Latch_Instr = {5'($urandom_range(1, 31)), 20'($urandom), 5'($urandom_range(6, 7)), 2'b0};
            end else if (kind == 1) begin
                alu = 5'($urandom_range(0, 29));
                if (alu >= 5'd6) alu = alu + 5'd2;
                DX_Latch_Instr = {5'd0, 20'($urandom), alu, 2'b0};
            end else begin
                DX_Latch_Instr = enc_md($urandom_range(0, 1) == 1, 5'($urandom));
                flush          = 1'b1;
            end
            DX_A_operand      = $urandom;
            DX_B_operand      = $urandom;
            multdiv_resultRDY = 1'b0;
            multdiv_exception = 1'b0;
            #1;
            check_eq($sformatf("idle stall %0d", i), md_stall, 32'd0);
            check_eq($sformatf("idle busy %0d", i), md_busy, 32'd0);
            check_eq($sformatf("idle start %0d", i), {ctrl_MULT, ctrl_DIV}, 32'd0);
            check_eq($sformatf("idle done %0d", i), md_done, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, b;
        bit          dv, ex;
        int          k, f;

        reset             = 1'b1;
        DX_Latch_Instr    = enc_md(1'b0, 5'd3);
        DX_A_operand      = 32'd1;
        DX_B_operand      = 32'd2;
        flush             = 1'b0;
        multdiv_resultRDY = 1'b0;
        multdiv_exception = 1'b0;
        multdiv_result    = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            check_eq("rst stall", md_stall, 32'd0);
            check_eq("rst bubble", md_XM_bubble, 32'd0);
            check_eq("rst start", {ctrl_MULT, ctrl_DIV}, 32'd0);
            check_eq("rst opA", md_operandA, 32'd0);
            check_eq("rst opB", md_operandB, 32'd0);
            check_eq("rst done", md_done, 32'd0);
            check_eq("rst result", md_result, 32'd0);
            check_eq("rst rd", md_rd, 32'd0);
            check_eq("rst error", md_error, 32'd0);
            check_eq("rst busy", md_busy, 32'd0);
        end
        @(negedge clock);
        reset          = 1'b0;
        DX_Latch_Instr = NOP;

        run_op(1'b0, 32'd6, 32'd7, 5'd12, 17, 1'b0, 0, 1'b1);
        run_op(1'b1, 32'd9, 32'd0, 5'd4, 5, 1'b1, 0, 1'b1);
        run_op(1'b1, 32'd100, 32'd7, 5'd8, 6, 1'b0, 0, 1'b0);
        run_op(1'b0, 32'd3, 32'd5, 5'd9, 4, 1'b0, 0, 1'b1);
        run_op(1'b0, 32'd11, 32'd13, 5'd2, 6, 1'b0, 4, 1'b1);
        run_op(1'b1, 32'd50, 32'd5, 5'd7, 1000, 1'b0, 0, 1'b1);
        run_op(1'b0, 32'd21, 32'd2, 5'd6, TO + 1, 1'b0, 0, 1'b1);
        run_op(1'b0, 32'd4, 32'd4, 5'd0, 2, 1'b0, 0, 1'b1);
        run_op(1'b0, 32'd8, 32'd3, 5'd1, 3, 1'b1, 0, 1'b1);
        idle_cycles(12);

        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            if (c == 0) DX_Latch_Instr = enc_md(1'b0, 5'd9);
            DX_A_operand = 32'd11;
            DX_B_operand = 32'd12;
        end
        #1;
        check_eq("pre-rst busy", md_busy, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("mid-rst stall", md_stall, 32'd0);
        check_eq("mid-rst bubble", md_XM_bubble, 32'd0);
        @(negedge clock);
        reset             = 1'b0;
        DX_Latch_Instr    = NOP;
        multdiv_resultRDY = 1'b1;
        multdiv_result    = 32'd132;
        #1;
        check_eq("post-rst busy", md_busy, 32'd0);
        check_eq("post-rst stall", md_stall, 32'd0);
        check_eq("post-rst start", {ctrl_MULT, ctrl_DIV}, 32'd0);
        check_eq("post-rst opA", md_operandA, 32'd0);
        check_eq("post-rst opB", md_operandB, 32'd0);
        check_eq("post-rst done", md_done, 32'd0);
        check_eq("post-rst result", md_result, 32'd0);
        check_eq("post-rst rd", md_rd, 32'd0);
        check_eq("post-rst error", md_error, 32'd0);
        @(negedge clock);
        multdiv_resultRDY = 1'b0;
        #1;
        check_eq("late rdy done", md_done, 32'd0);
        check_eq("late rdy busy", md_busy, 32'd0);
        run_op(1'b0, 32'd11, 32'd12, 5'd9, 3, 1'b0, 0, 1'b1);

        for (int i = 0; i < 30; i++) begin
            dv   = ($urandom_range(0, 1) == 1);
            a    = $urandom;
            b    = (dv && $urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 1000);
            ex   = (dv && b == 32'd0) || ($urandom_range(0, 7) == 0);
            k    = $urandom_range(2, 25);
            f    = ($urandom_range(0, 5) == 0) ? $urandom_range(1, k) : 0;
            spur = ($urandom_range(0, 1) == 1);
            run_op(dv, a, b, 5'($urandom), k, ex, f, ($urandom_range(0, 1) == 1));
        end
        spur = 1'b0;
        idle_cycles(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Sequences the multi-cycle multiplier/divider for the 5-stage pipeline. It detects `mul`/`div` in the DX latch, launches the multdiv unit with a one-cycle start pulse, and holds PC/FD/DX while feeding bubbles into XM. When the unit finishes, it hands a registered result, destination register and error flag to the XM-latch input mux. It sits beside the hazard detection unit; its stall and bubble outputs are OR-ed with the load-use stall.

## Interface

Parameters:

- `TIMEOUT`, default 64: maximum WAIT cycles before a forced error completion.
- `MUL_ERR_CODE`, default 4: rstatus value on a multiply exception.
- `DIV_ERR_CODE`, default 5: rstatus value on a divide exception or timeout.

Ports:

- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `DX_Latch_Instr` in 32: instruction in DX. Field layout: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], ALU_op[6:2].
- `DX_A_operand` in 32: bypassed rs value.
- `DX_B_operand` in 32: bypassed rt value.
- `flush` in 1: DX contents are being squashed this cycle.
- `multdiv_resultRDY` in 1: multdiv unit result valid.
- `multdiv_exception` in 1: multdiv unit exception, valid with resultRDY.
- `multdiv_result` in 32: multdiv unit result.
- `ctrl_MULT` out 1: one-cycle multiply start pulse.
- `ctrl_DIV` out 1: one-cycle divide start pulse.
- `md_operandA` out 32: held operand A.
- `md_operandB` out 32: held operand B.
- `md_stall` out 1: freeze PC, FD and DX latches.
- `md_XM_bubble` out 1: load nop into XM.
- `md_done` out 1: select md_* values into XM this cycle.
- `md_result` out 32: result, or error code on error.
- `md_rd` out 5: destination register; 30 on error.
- `md_error` out 1: drives the XM error-flag latch input.
- `md_busy` out 1: state is not IDLE.

## Operation

- Detect: `is_md` = (opcode==0) and (ALU_op==6 for mul, or ALU_op==7 for div).
- States: IDLE, START, WAIT, DONE. Encoding is free. Registered state; outputs decoded from state plus `is_md` in IDLE.
- IDLE
  - `md_stall` = `md_XM_bubble` = `is_md` and not `flush`.
  - If `is_md` and not `flush`: capture A, B, rd and op (mul/div), then go to START.
  - Otherwise stay in IDLE.
- START
  - Exactly one of `ctrl_MULT`/`ctrl_DIV` = 1, matching the captured op.
  - `md_stall` = 1, `md_XM_bubble` = 1.
  - Clear the cycle counter; go to WAIT.
  - `resultRDY` in this cycle is ignored.
- WAIT
  - `md_stall` = 1, `md_XM_bubble` = 1; counter increments.
  - `resultRDY` = 1: register result and exception, go to DONE.
  - Counter == `TIMEOUT`-1 with no `resultRDY`: register timeout error, go to DONE.
- DONE
  - `md_stall` = 0, `md_XM_bubble` = 0, `md_done` = 1; always returns to IDLE.
  - No exception: `md_result` = captured result, `md_rd` = captured rd, `md_error` = 0.
  - Multdiv exception: `md_result` = `MUL_ERR_CODE` or `DIV_ERR_CODE`, `md_rd` = 30, `md_error` = 1.
  - Timeout: `md_result` = `DIV_ERR_CODE`, `md_rd` = 30, `md_error` = 1.
  - The DX instruction advances at the end of DONE, so the same instruction never re-triggers.
- `flush` in START or WAIT: abort to IDLE next cycle, no `md_done`; a late `resultRDY` is ignored.
- `flush` in DONE: `md_done` still pulses; top level discards it.
- rd==0: the operation runs normally and `md_rd` = 0 (the write is dropped by the register file).
- Operands are held in registers from START until the next capture; they are insensitive to DX changes.
- Outside DONE: `md_result`, `md_rd` and `md_error` are 0.

## Timing

- Reset (synchronous): state IDLE, counter 0. Every registered output is 0: `ctrl_MULT`, `ctrl_DIV`, `md_operandA`, `md_operandB`, `md_done`, `md_result`, `md_rd`, `md_error`, `md_busy`.
- During reset, `md_stall` and `md_XM_bubble` are 0 regardless of DX.
- Reset mid-operation aborts with no `md_done`; any in-flight unit result is ignored.
- Cycle 0: mul enters DX, IDLE, stall=1.
- Cycle 1: START, start pulse.
- Cycles 2 to k: WAIT; `resultRDY` arrives in cycle k.
- Cycle k+1: DONE, `md_done`=1.
- Total stall = k+1 cycles. Minimum k=2, giving a 3-cycle stall.
- Back-to-back mul/div: the second starts in the IDLE cycle immediately after DONE. There are no idle stall-free cycles unless the next DX instruction is not md.
- Counter width is `$clog2(TIMEOUT)`+1. The counter saturates; it never wraps.

## Test plan

- mul A=6, B=7, `resultRDY` 16 cycles after the pulse with result 42:
  - `ctrl_MULT` high exactly 1 cycle;
  - stall for 18 cycles;
  - `md_done` cycle shows result 42 with `md_rd`=rd and `md_error`=0.
- div A=9, B=0, unit raises exception with `resultRDY`: `md_done` with `md_result`=5, `md_rd`=30, `md_error`=1; next cycle IDLE.
- Two consecutive div 100/7 then mul 3*5:
  - `md_done` values 14 then 15;
  - `ctrl_DIV`, then `ctrl_MULT`, pulses separated by exactly one DONE and one IDLE cycle.
- `flush` asserted in the 3rd WAIT cycle, then `resultRDY` arrives:
  - no `md_done`; stall drops the cycle after flush;
  - the late result is ignored.
- `resultRDY` never asserted with `TIMEOUT`=64: DONE in cycle 65 after START, `md_error`=1, `md_result`=5.
- `reset` pulsed mid-WAIT:
  - all outputs 0 the following cycle;
  - a subsequent mul restarts from IDLE with a fresh pulse.
